// File: rtl/d_sram_to_sram_like_if.sv
// sram-like data bus between the data-side bridge (master) and the AXI interconnect (slave).
interface d_sram_to_sram_like_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: one-cycle SRAM requests from the M stage become single sram-like
// transactions; load data is held until the whole pipeline is released.
module d_sram_to_sram_like #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          longest_stall,
  input  logic                          data_sram_en,
  input  logic                          data_sram_wr,
  input  logic [3:0]                    data_sram_sel,
  input  logic [31:0]                   data_sram_addr,
  input  logic [31:0]                   data_sram_wdata,
  output logic [31:0]                   data_sram_rdata,
  output logic                          d_stall,
  d_sram_to_sram_like_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  function automatic logic [1:0] size_of_sel(input logic [3:0] sel);
    logic [1:0] size;
    case (sel)
      4'b1111:                            size = 2'd2;
      4'b0011, 4'b1100:                   size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

  // kseg0/kseg1 both alias the low 512 MiB of physical memory
  function automatic logic [31:0] map_addr(input logic [31:0] vaddr);
    logic [31:0] paddr;
    if (KSEG_MAP && (vaddr[31:30] == 2'b10)) begin
      paddr = {3'b000, vaddr[28:0]};
    end else begin
      paddr = vaddr;
    end
    return paddr;
  endfunction

  // State and read-data buffer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdata_buf_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Next-state logic; a flushed access (en dropped while waiting) discards its response
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      IDLE: begin
        if (data_sram_en && bus.data_addr_ok) begin
          state_d = WAIT_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DATA: begin
        if (bus.data_data_ok) begin
          rdata_buf_d = bus.data_rdata;
          if (data_sram_en) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT_DATA;
        end
      end
      DONE: begin
        if (!longest_stall || !data_sram_en) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request side is combinational from the core; M is frozen while d_stall is high
  always_comb begin
    bus.data_req    = data_sram_en && (state_q == IDLE);
    bus.data_wr     = data_sram_wr;
    bus.data_size   = size_of_sel(data_sram_sel);
    bus.data_addr   = map_addr(data_sram_addr);
    bus.data_wdata  = data_sram_wdata;
    d_stall         = data_sram_en && (state_q != DONE);
    data_sram_rdata = rdata_buf_q;
  end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Randomized self-checking bench for d_sram_to_sram_like against a transaction-timing model.
module tb_d_sram_to_sram_like;

  logic        clk = 1'b0;
  logic        rst;
  logic        longest_stall;
  logic        en;
  logic        wr;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata, sram_rdata_raw;
  logic        d_stall, d_stall_raw;

  int          checks = 0;
  int          failures = 0;
  int          hs_count = 0;
  int          exp_hs = 0;
  logic [31:0] exp_buf = 32'h0;

  d_sram_to_sram_like_if bus();
  d_sram_to_sram_like_if bus_raw();

  always #5 clk = ~clk;

  d_sram_to_sram_like #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst), .longest_stall(longest_stall),
    .data_sram_en(en), .data_sram_wr(wr), .data_sram_sel(sel),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(sram_rdata), .d_stall(d_stall), .bus(bus.master)
  );

  d_sram_to_sram_like #(.KSEG_MAP(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .longest_stall(longest_stall),
    .data_sram_en(en), .data_sram_wr(wr), .data_sram_sel(sel),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(sram_rdata_raw), .d_stall(d_stall_raw), .bus(bus_raw.master)
  );

  always @(posedge clk) begin
    if (rst && bus.data_req && bus.data_addr_ok) hs_count <= hs_count + 1;
  end

  function automatic logic [1:0] exp_size(input logic [3:0] s);
    if ($countones(s) == 1) return 2'd0;
    if (s == 4'b0011 || s == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input bit kseg);
    if (kseg && (a >> 30) == 32'd2) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  // One access: addr_ok n cycles after start, data_ok m cycles after accept,
  // then DONE held by an external stall for 'hold' cycles before release.
  task automatic do_access(input logic [31:0] a, input logic [3:0] s, input logic w,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int n, input int m, input int hold, input string tag);
    int last;
    last = n + m + 1 + hold;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      en = 1'b1; wr = w; sel = s; addr = a; wdata = wd;
      bus.data_addr_ok = (k == n);
      bus.data_data_ok = (k == n + m);
      bus.data_rdata   = (k == n + m) ? rd : $urandom;
      longest_stall    = (k < last);
      if (k == n + m + 1) exp_buf = rd;
      #1;
      checks++;
      if (bus.data_req !== (k <= n)) begin
        failures++;
        $display("FAIL %s req k=%0d got=%b exp=%b", tag, k, bus.data_req, (k <= n));
      end
      checks++;
      if (d_stall !== (k <= n + m)) begin
        failures++;
        $display("FAIL %s d_stall k=%0d got=%b exp=%b", tag, k, d_stall, (k <= n + m));
      end
      checks++;
      if (sram_rdata !== exp_buf) begin
        failures++;
        $display("FAIL %s rdata k=%0d got=%h exp=%h", tag, k, sram_rdata, exp_buf);
      end
      checks++;
      if (bus.data_addr !== exp_addr(a, 1'b1) || bus_raw.data_addr !== a) begin
        failures++;
        $display("FAIL %s addr k=%0d got=%h/%h exp=%h/%h", tag, k, bus.data_addr,
                 bus_raw.data_addr, exp_addr(a, 1'b1), a);
      end
      checks++;
      if (bus.data_wr !== w || bus.data_wdata !== wd || bus.data_size !== exp_size(s)) begin
        failures++;
        $display("FAIL %s wr/wdata/size k=%0d got=%b/%h/%0d exp=%b/%h/%0d", tag, k,
                 bus.data_wr, bus.data_wdata, bus.data_size, w, wd, exp_size(s));
      end
    end
    exp_hs++;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en = 1'b0; longest_stall = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #1;
      checks++;
      if (bus.data_req !== 1'b0 || d_stall !== 1'b0 || sram_rdata !== exp_buf) begin
        failures++;
        $display("FAIL %s idle got req=%b stall=%b rdata=%h exp req=0 stall=0 rdata=%h",
                 tag, bus.data_req, d_stall, sram_rdata, exp_buf);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; wr = 1'b0; sel = 4'b0; addr = 32'h0; wdata = 32'h0;
    longest_stall = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    bus_raw.data_addr_ok = 1'b0; bus_raw.data_data_ok = 1'b0; bus_raw.data_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (sram_rdata !== 32'h0 || bus.data_req !== 1'b0 || d_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdata=%h req=%b stall=%b exp 0/0/0",
               sram_rdata, bus.data_req, d_stall);
    end
  endtask

  task automatic test_load_word();
    do_access(32'h8000_1000, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, "load_word");
    checks++;
    if (sram_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_word_value got=%h exp=deadbeef", sram_rdata);
    end
    idle_cycles(2, "after_load");
  endtask

  task automatic test_store_byte();
    do_access(32'h0000_2002, 4'b0100, 1'b1, 32'h00AB_0000, 32'h1234_5678, 3, 2, 0, "store_byte");
    idle_cycles(1, "after_store");
  endtask

  task automatic test_done_hold();
    do_access(32'hA000_0040, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 2, 5, "done_hold");
    idle_cycles(1, "after_hold");
  endtask

  task automatic test_flush();
    int n, m;
    logic [31:0] rd;
    n = $urandom_range(0, 2); m = $urandom_range(1, 3); rd = $urandom;
    for (int k = 0; k <= n + m; k++) begin
      @(negedge clk);
      en = (k <= n); wr = 1'b0; sel = 4'b1111; addr = 32'h0000_3000;
      longest_stall = 1'b0;
      bus.data_addr_ok = (k == n);
      bus.data_data_ok = (k == n + m);
      bus.data_rdata   = rd;
      #1;
      checks++;
      if (bus.data_req !== (k <= n) || d_stall !== (k <= n)) begin
        failures++;
        $display("FAIL flush k=%0d got req=%b stall=%b exp req=%b stall=%b",
                 k, bus.data_req, d_stall, (k <= n), (k <= n));
      end
    end
    exp_hs++;
    exp_buf = rd;
    do_access(32'h0000_3004, 4'b0011, 1'b0, 32'h0, 32'h5A5A_A5A5, 0, 1, 0, "after_flush");
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_count;
    do_access(32'h8000_0100, 4'b1111, 1'b0, 32'h0, 32'h1111_1111, 0, 1, 0, "b2b_first");
    do_access(32'h8000_0104, 4'b1111, 1'b0, 32'h0, 32'h2222_2222, 0, 1, 0, "b2b_second");
    idle_cycles(1, "after_b2b");
    checks++;
    if (hs_count - hs0 !== 2) begin
      failures++;
      $display("FAIL b2b_handshakes got=%0d exp=2", hs_count - hs0);
    end
  endtask

  task automatic test_spurious_data_ok();
    @(negedge clk);
    en = 1'b0; longest_stall = 1'b0; bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    #1;
    checks++;
    if (sram_rdata !== exp_buf) begin
      failures++;
      $display("FAIL spurious_data_ok got=%h exp=%h", sram_rdata, exp_buf);
    end
    do_access(32'h0000_4000, 4'b1000, 1'b0, 32'h0, 32'h0000_0077, 1, 1, 0, "after_spurious");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    en = 1'b1; wr = 1'b0; sel = 4'b1111; addr = 32'h0000_5000; longest_stall = 1'b1;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; bus.data_addr_ok = 1'b0; longest_stall = 1'b0;
    exp_hs++;
    @(negedge clk);
    rst = 1'b1;
    exp_buf = 32'h0;
    #1;
    checks++;
    if (sram_rdata !== 32'h0 || d_stall !== 1'b0 || bus.data_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got rdata=%h stall=%b req=%b exp 0/0/0",
               sram_rdata, d_stall, bus.data_req);
    end
    do_access(32'h0000_5000, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 1, 0, "after_reset");
  endtask

  task automatic test_kseg_off();
    logic [31:0] tbl [4];
    tbl[0] = 32'h8000_1000; tbl[1] = 32'hA000_0004; tbl[2] = 32'h4000_0010; tbl[3] = 32'hC000_0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'b0; addr = tbl[i];
      #1;
      checks++;
      if (bus_raw.data_addr !== tbl[i] || bus.data_addr !== exp_addr(tbl[i], 1'b1)) begin
        failures++;
        $display("FAIL kseg addr got raw=%h mapped=%h exp raw=%h mapped=%h", bus_raw.data_addr,
                 bus.data_addr, tbl[i], exp_addr(tbl[i], 1'b1));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] sels [10];
    sels[0] = 4'b1111; sels[1] = 4'b0011; sels[2] = 4'b1100; sels[3] = 4'b0001; sels[4] = 4'b0010;
    sels[5] = 4'b0100; sels[6] = 4'b1000; sels[7] = 4'b0101; sels[8] = 4'b0110; sels[9] = 4'b0000;
    for (int i = 0; i < 25; i++) begin
      do_access($urandom, sels[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3), "random");
      idle_cycles($urandom_range(0, 2), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_done_hold();
    test_flush();
    test_back_to_back();
    test_spurious_data_ok();
    test_reset_mid();
    test_kseg_off();
    test_random();
    idle_cycles(1, "final");
    checks++;
    if (hs_count !== exp_hs) begin
      failures++;
      $display("FAIL handshake_total got=%0d exp=%0d", hs_count, exp_hs);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
